// File: rtl/serial_compare_controller.sv
// ---------------------------------------------------------------------------
// serial_compare_controller
//
// Purpose:
//   Compares two unsigned WIDTH-bit operands one bit pair per clock, MSB
//   first. It reports A<B, A==B or A>B with a valid/ready handshake on each
//   side. Only one operand pair is in flight at a time.
//
// Optional feature (compile-time macro):
//   SERIAL_CMP_EARLY_EXIT_EN - when defined, the compare finishes on the
//   first differing bit pair. When undefined, every compare takes WIDTH steps.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst          - asynchronous reset, active low
//   in_valid     - operand pair on a/b is valid
//   in_ready     - block can accept an operand pair (IDLE only)
//   a, b         - parallel operands, captured on the accept edge
//   out_valid    - result outputs are valid (DONE only)
//   out_ready    - consumer accepts the result
//   a_less_b     - result A < B (unsigned)
//   a_eq_b       - result A == B
//   a_greater_b  - result A > B (unsigned)
//   bits_used    - number of bit-serial steps consumed for the result
// ---------------------------------------------------------------------------
module serial_compare_controller #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_less_b,
    output logic             a_eq_b,
    output logic             a_greater_b,
    output logic [CW-1:0]    bits_used
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             a_bit;
    logic             b_bit;
    logic             last_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        cnt_d     = cnt_q;
        // The current bit pair is always at the top of the shift registers.
        a_bit     = a_sh_q[WIDTH-1];
        b_bit     = b_sh_q[WIDTH-1];
        // The step counter holds the steps already taken, so WIDTH-1 means
        // this step consumes bit 0.
        last_step = (cnt_q == CW'(WIDTH - 1));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q << 1;
                cnt_d  = cnt_q + CW'(1);
                // Once a difference is seen, the first difference decides the result.
                if (eq_q) begin
                    eq_d = (a_bit == b_bit);
                    lt_d = ~a_bit & b_bit;
                    gt_d = a_bit & ~b_bit;
                end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (last_step || (eq_q && (a_bit != b_bit))) begin
                    state_d = DONE;
                end
`else
                if (last_step) begin
                    state_d = DONE;
                end
`endif
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The result outputs are forced to zero outside DONE. This keeps the
    // internal flags and counter hidden until the result is valid.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign a_less_b    = out_valid & lt_q;
    assign a_eq_b      = out_valid & eq_q;
    assign a_greater_b = out_valid & gt_q;
    assign bits_used   = out_valid ? cnt_q : '0;

endmodule

// File: tb/tb_serial_compare_controller.sv
// ---------------------------------------------------------------------------
// tb_serial_compare_controller
//
// Directed bench for serial_compare_controller. It uses one WIDTH=8 instance
// and one WIDTH=1 instance. Expected latencies and bits_used depend on
// SERIAL_CMP_EARLY_EXIT_EN. All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_serial_compare_controller;

    logic       clk;
    logic       rst;

    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0] a8, b8;
    logic       lt8, eq8, gt8;
    logic [3:0] bits8;

    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0] a1, b1;
    logic       lt1, eq1, gt1;
    logic [0:0] bits1;

    int n_checks;
    int n_fail;

    serial_compare_controller #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .a_less_b(lt8), .a_eq_b(eq8), .a_greater_b(gt8),
        .bits_used(bits8)
    );

    serial_compare_controller #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .a_less_b(lt1), .a_eq_b(eq1), .a_greater_b(gt1),
        .bits_used(bits1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a pair at a negedge and returns at the negedge after the accept edge.
    task automatic accept8(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a8        = av;
        b8        = bv;
        in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen, capped at 20.
    task automatic wait_valid8(output int lat);
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release8();
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        n_checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_hs: in_ready=%b out_valid=%b, required 1 0", in_ready8, out_valid8);
        end
        n_checks++;
        if ({lt8, eq8, gt8} !== 3'b000 || bits8 !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_res: flags=%b bits=%0d, required 000 0", {lt8, eq8, gt8}, bits8);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_greater();
        int lat;
        int exp_lat;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        exp_lat = 1;
`else
        exp_lat = 8;
`endif
        accept8(8'h80, 8'h7F);
        n_checks++;
        if (out_valid8 !== 1'b0 && exp_lat > 1) begin
            n_fail++;
            $display("[TB] FAIL gt_early_valid: out_valid=%b, required 0", out_valid8);
        end
        wait_valid8(lat);
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("[TB] FAIL gt_latency: got %0d, required %0d", lat, exp_lat);
        end
        n_checks++;
        if ({lt8, eq8, gt8} !== 3'b001 || bits8 !== 4'(exp_lat) || in_ready8 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL gt_result: flags=%b bits=%0d in_ready=%b, required 001 %0d 0",
                     {lt8, eq8, gt8}, bits8, in_ready8, exp_lat);
        end
        release8();
    endtask

    task automatic test_equal();
        int lat;
        accept8(8'h3C, 8'h3C);
        wait_valid8(lat);
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("[TB] FAIL eq_latency: got %0d, required 8", lat);
        end
        n_checks++;
        if ({lt8, eq8, gt8} !== 3'b010 || bits8 !== 4'd8) begin
            n_fail++;
            $display("[TB] FAIL eq_result: flags=%b bits=%0d, required 010 8", {lt8, eq8, gt8}, bits8);
        end
        release8();
    endtask

    task automatic test_less();
        int lat;
        accept8(8'h12, 8'h13);
        wait_valid8(lat);
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("[TB] FAIL lt_latency: got %0d, required 8", lat);
        end
        n_checks++;
        if ({lt8, eq8, gt8} !== 3'b100 || bits8 !== 4'd8) begin
            n_fail++;
            $display("[TB] FAIL lt_result: flags=%b bits=%0d, required 100 8", {lt8, eq8, gt8}, bits8);
        end
        release8();
    endtask

    // Operands and in_valid are disturbed during SHIFT. The captured pair must still win.
    task automatic test_input_change();
        int lat;
        accept8(8'h55, 8'h54);
        a8        = 8'h00;
        b8        = 8'hFF;
        in_valid8 = 1'b1;
        n_checks++;
        if (in_ready8 !== 1'b0 || out_valid8 !== 1'b0 || bits8 !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL shift_outputs: in_ready=%b out_valid=%b bits=%0d, required 0 0 0",
                     in_ready8, out_valid8, bits8);
        end
        wait_valid8(lat);
        in_valid8 = 1'b0;
        n_checks++;
        if (lat !== 8 || {lt8, eq8, gt8} !== 3'b001 || bits8 !== 4'd8) begin
            n_fail++;
            $display("[TB] FAIL capture_hold: lat=%0d flags=%b bits=%0d, required 8 001 8",
                     lat, {lt8, eq8, gt8}, bits8);
        end
        release8();
    endtask

    task automatic test_hold();
        int lat;
        int exp_bits;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        exp_bits = 1;
`else
        exp_bits = 8;
`endif
        accept8(8'hA5, 8'h5A);
        wait_valid8(lat);
        for (int i = 0; i < 5; i++) begin
            a8        = 8'(i * 37);
            b8        = 8'(~(i * 37));
            in_valid8 = i[0];
            @(negedge clk);
            n_checks++;
            if (out_valid8 !== 1'b1 || {lt8, eq8, gt8} !== 3'b001 ||
                bits8 !== 4'(exp_bits) || in_ready8 !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL hold_%0d: valid=%b flags=%b bits=%0d in_ready=%b, required 1 001 %0d 0",
                         i, out_valid8, {lt8, eq8, gt8}, bits8, in_ready8, exp_bits);
            end
        end
        in_valid8 = 1'b0;
        release8();
        n_checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || bits8 !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL hold_release: in_ready=%b out_valid=%b bits=%0d, required 1 0 0",
                     in_ready8, out_valid8, bits8);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int exp_lat;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        exp_lat = 7;
`else
        exp_lat = 8;
`endif
        accept8(8'hFF, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || {lt8, eq8, gt8} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_mid: out_valid=%b in_ready=%b flags=%b, required 0 1 000",
                     out_valid8, in_ready8, {lt8, eq8, gt8});
        end
        @(negedge clk);
        rst = 1'b1;
        accept8(8'h01, 8'h02);
        wait_valid8(lat);
        n_checks++;
        if (lat !== exp_lat || {lt8, eq8, gt8} !== 3'b100 || bits8 !== 4'(exp_lat)) begin
            n_fail++;
            $display("[TB] FAIL after_reset: lat=%0d flags=%b bits=%0d, required %0d 100 %0d",
                     lat, {lt8, eq8, gt8}, bits8, exp_lat, exp_lat);
        end
        release8();
    endtask

    task automatic test_width1();
        int lat;
        @(negedge clk);
        a1        = 1'b1;
        b1        = 1'b0;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 1 || {lt1, eq1, gt1} !== 3'b001 || bits1 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL w1_result: lat=%0d flags=%b bits=%0d, required 1 001 1",
                     lat, {lt1, eq1, gt1}, bits1);
        end
        out_ready1 = 1'b1;
        @(negedge clk);
    endtask

    // With in_valid and out_ready held high, a result should appear every third cycle.
    task automatic test_back_to_back();
        int first;
        int prev;
        int seen;
        int bad_gap;
        first   = -1;
        prev    = -1;
        seen    = 0;
        bad_gap = 0;
        a1        = 1'b0;
        b1        = 1'b1;
        in_valid1 = 1'b1;
        out_ready1 = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid1) begin
                if (prev >= 0 && (c - prev) != 3) bad_gap++;
                if (first < 0) first = c;
                prev = c;
                seen++;
            end
        end
        in_valid1 = 1'b0;
        n_checks++;
        if (seen !== 5 || bad_gap !== 0) begin
            n_fail++;
            $display("[TB] FAIL back_to_back: results=%0d bad_gaps=%0d, required 5 0", seen, bad_gap);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL w1_idle: in_ready=%b out_valid=%b, required 1 0", in_ready1, out_valid1);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        a8         = '0;
        b8         = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        a1         = '0;
        b1         = '0;

        test_reset();
        test_greater();
        test_equal();
        test_less();
        test_input_change();
        test_hold();
        test_reset_mid();
        test_width1();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_compare_controller.md
SERIAL_COMPARE_CONTROLLER -- requirements
Module: serial_compare_controller

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  operand A, parallel.
REQ-007 b  input  WIDTH  operand B, parallel.
REQ-008 out_valid  output  1  result outputs are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 a_less_b  output  1  result: A < B, unsigned.
REQ-011 a_eq_b  output  1  result: A == B.
REQ-012 a_greater_b  output  1  result: A > B, unsigned.
REQ-013 bits_used  output  $clog2(WIDTH+1)  number of bit-serial compare steps used for the current result.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and 0 in SHIFT and DONE.
REQ-016 Accept: in IDLE with in_valid=1, the block SHALL capture a and b into shift registers, set the internal flags to eq=1/lt=0/gt=0, clear the step counter, and enter SHIFT.
REQ-017 SHIFT: each cycle, the block SHALL consume one bit pair MSB-first (bit WIDTH-1 first) and increment the step counter.
REQ-018 Flag update per step: if eq=1, then eq<=(a_bit==b_bit), lt<=(~a_bit&b_bit), gt<=(a_bit&~b_bit); if eq=0, lt and gt SHALL hold.
REQ-019 SHIFT->DONE SHALL occur on the edge that consumes bit 0, so that out_valid rises exactly WIDTH cycles after the accept edge.
REQ-020 In DONE, out_valid SHALL be 1 and the three result outputs SHALL equal the flags, exactly one-hot.
REQ-021 The value of bits_used in DONE SHALL be the number of steps consumed.
REQ-022 Results and bits_used SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 DONE->IDLE SHALL occur on an edge with out_ready=1.
REQ-024 in_ready SHALL be asserted the cycle after the result handshake; there is no overlap of result and accept.
REQ-025 Outside DONE, out_valid, a_less_b, a_eq_b, a_greater_b and bits_used SHALL all be 0.
REQ-026 WIDTH=1 SHALL work with one SHIFT cycle.
REQ-027 in_valid during SHIFT or DONE SHALL be ignored and SHALL NOT disturb the captured operands.
REQ-028 Changes on a or b after the accept edge SHALL NOT affect the result.

Reset
REQ-029 Asserting rst (rst=0) SHALL asynchronously force IDLE, clear the shift registers and step counter, set the flags to eq=1/lt=0/gt=0, and drive out_valid=0, all result outputs=0, bits_used=0 and in_ready=1.
REQ-030 Reset asserted mid-SHIFT or mid-DONE SHALL abort the operation with no result emitted.
REQ-031 Reset deassertion SHALL be synchronized to the clock edge, with the first accept possible on the first edge after release.

Configuration
REQ-032 Macro SERIAL_CMP_EARLY_EXIT_EN defined: SHIFT SHALL go to DONE on the edge whose step makes eq=0, with bits_used equal to the steps taken (1..WIDTH); equal operands still take WIDTH steps.
REQ-033 Macro undefined: the block SHALL always take WIDTH steps, with bits_used=WIDTH; early-exit logic is absent.

Verification
REQ-034 WIDTH=8, a=0x80, b=0x7F -> a_greater_b=1; macro off: out_valid at accept+8, bits_used=8; macro on: out_valid at accept+1, bits_used=1.
REQ-035 a=0x3C, b=0x3C -> a_eq_b=1 at accept+8, bits_used=8 in both builds.
REQ-036 a=0x12, b=0x13 -> a_less_b=1; macro on: bits_used=8, out_valid at accept+8.
REQ-037 Hold out_ready=0 for 5 cycles in DONE while toggling a/b/in_valid -> outputs stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-038 Assert rst=0 mid-SHIFT (step 3 of a=0xFF, b=0x00) -> immediate out_valid=0, in_ready=1; a new pair a=0x01, b=0x02 then yields a_less_b=1.
REQ-039 WIDTH=1, a=1, b=0 -> a_greater_b=1 at accept+1, bits_used=1; back-to-back pairs with out_ready tied 1 -> one result every 3 cycles.
